// File: rtl/sa_result_drain_4x4_if.sv
// Result stream port of the 4x4 systolic array drain.
// Master drives words, slave returns m_ready.
interface sa_result_drain_4x4_if #(
  parameter int DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;
  logic [3:0]              m_row;
  logic [1:0]              m_col;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    output m_row,
    output m_col,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    input  m_row,
    input  m_col,
    output m_ready
  );
endinterface

// File: rtl/sa_result_drain_4x4.sv
// Systolic array result reader: waits, pulses result_ld, captures
// ROWS beats of 4 columns, then streams them out row-major.
module sa_result_drain_4x4 #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int LD_DELAY   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    result_ld,
  input  logic [2*DATA_WIDTH-1:0] sa_GD0,
  input  logic [2*DATA_WIDTH-1:0] sa_GD1,
  input  logic [2*DATA_WIDTH-1:0] sa_GD2,
  input  logic [2*DATA_WIDTH-1:0] sa_GD3,
  sa_result_drain_4x4_if.master   m_if
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW = RW + 2;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [AW-1:0] W_LAST   = AW'(4 * ROWS - 1);
  localparam logic [15:0]   D_LAST   =
    16'((LD_DELAY > 0) ? LD_DELAY - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]    r_state;
  logic [15:0]   r_dcnt;
  logic [RW-1:0] r_rcnt;
  logic [AW-1:0] r_wcnt;
  logic          r_valid;
  logic          r_done;
  logic          r_ld;
  logic [WW-1:0] r_buf [2**AW];

  logic w_acc;
  logic w_last;

  assign w_last = (r_wcnt == W_LAST);
  assign w_acc  = r_valid & m_if.m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**AW; i++) begin
        r_buf[i] <= '0;
      end
    end else if (r_state == S_CAPT) begin
      r_buf[{r_rcnt, 2'd0}] <= sa_GD0;
      r_buf[{r_rcnt, 2'd1}] <= sa_GD1;
      r_buf[{r_rcnt, 2'd2}] <= sa_GD2;
      r_buf[{r_rcnt, 2'd3}] <= sa_GD3;
    end
  end

  // A start seen while done is still high belongs to the old job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
      r_rcnt  <= '0;
      r_wcnt  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ld    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ld   <= 1'b0;
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (start && !r_done) begin
            r_dcnt <= '0;
            if (LD_DELAY == 0) begin
              r_state <= S_LOAD;
              r_ld    <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        (r_state == S_WAIT): begin
          if (r_dcnt == D_LAST) begin
            r_state <= S_LOAD;
            r_ld    <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 16'd1;
          end
        end
        (r_state == S_LOAD): begin
          r_state <= S_CAPT;
          r_rcnt  <= '0;
        end
        (r_state == S_CAPT): begin
          if (r_rcnt == ROW_LAST) begin
            r_state <= S_DRAIN;
            r_valid <= 1'b1;
            r_wcnt  <= '0;
          end else begin
            r_rcnt <= r_rcnt + RW'(1);
          end
        end
        (r_state == S_DRAIN): begin
          if (w_acc) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_wcnt <= r_wcnt + AW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result_ld = r_ld;

  assign m_if.m_valid = r_valid;
  assign m_if.m_data  = r_valid ? r_buf[r_wcnt] : '0;
  assign m_if.m_row   = r_valid ? 4'(r_wcnt >> 2) : 4'd0;
  assign m_if.m_col   = r_valid ? r_wcnt[1:0] : 2'd0;
  assign m_if.m_last  = r_valid & w_last;

endmodule

// File: tb/tb_sa_result_drain_4x4.sv
// Bench for sa_result_drain_4x4: schedule-based reference model
// for the default build plus a directed LD_DELAY=0, ROWS=1 build.
module tb_sa_result_drain_4x4;

  localparam int DW = 16;
  localparam int D  = 8;
  localparam int R  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        a_start, a_busy, a_done, a_ld;
  logic [31:0] a_gd [4];
  sa_result_drain_4x4_if #(.DATA_WIDTH(DW)) ifa ();

  sa_result_drain_4x4 #(
    .DATA_WIDTH(DW), .ROWS(R), .LD_DELAY(D)
  ) dut_a (
    .clk(clk), .rst(rst_n), .start(a_start),
    .busy(a_busy), .done(a_done), .result_ld(a_ld),
    .sa_GD0(a_gd[0]), .sa_GD1(a_gd[1]),
    .sa_GD2(a_gd[2]), .sa_GD3(a_gd[3]),
    .m_if(ifa.master)
  );

  logic        b_start, b_busy, b_done, b_ld;
  logic [31:0] b_gd [4];
  sa_result_drain_4x4_if #(.DATA_WIDTH(DW)) ifb ();

  sa_result_drain_4x4 #(
    .DATA_WIDTH(DW), .ROWS(1), .LD_DELAY(0)
  ) dut_b (
    .clk(clk), .rst(rst_n), .start(b_start),
    .busy(b_busy), .done(b_done), .result_ld(b_ld),
    .sa_GD0(b_gd[0]), .sa_GD1(b_gd[1]),
    .sa_GD2(b_gd[2]), .sa_GD3(b_gd[3]),
    .m_if(ifb.master)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: job timeline counted in edges since start
  typedef struct {
    logic [31:0] d;
    int          row;
    int          col;
  } word_t;

  word_t q[$];
  bit    mb, e_ld, e_valid, e_done;
  int    t;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      mb = 0; e_ld = 0; e_valid = 0; e_done = 0; t = 0;
    end else if (!mb) begin
      if (a_start && !e_done) begin
        mb = 1;
        t  = 0;
      end
      e_done = 0;
    end else begin
      t++;
      if (t >= D + 2 && t <= D + 1 + R)
        for (int c = 0; c < 4; c++)
          q.push_back('{a_gd[c], t - D - 2, c});
      if (e_valid && ifa.m_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          mb     = 0;
          e_done = 1;
        end
      end
      e_valid = mb && (t >= D + 1 + R);
    end
    e_ld = mb && (t == D);
  end

  int          ld_cnt, done_cnt, ld_cyc, done_cyc;
  int          fv_cyc, first_acc, last_acc;
  logic [31:0] obs[$];
  bit          st_prev = 0;
  logic [31:0] h_data;
  logic [3:0]  h_row;
  logic [1:0]  h_col;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("busy", a_busy, mb);
      chk("result_ld", a_ld, e_ld);
      chk("done", a_done, e_done);
      chk("m_valid", ifa.m_valid, e_valid);
      if (e_valid && q.size() > 0) begin
        chk("m_data", ifa.m_data, q[0].d);
        chk("m_row", ifa.m_row, q[0].row);
        chk("m_col", ifa.m_col, q[0].col);
        chk("m_last", ifa.m_last, q.size() == 1);
      end
      if (st_prev) begin
        chk("hold_data", ifa.m_data, h_data);
        chk("hold_row", ifa.m_row, h_row);
        chk("hold_col", ifa.m_col, h_col);
      end
      st_prev = ifa.m_valid && !ifa.m_ready;
      h_data  = ifa.m_data;
      h_row   = ifa.m_row;
      h_col   = ifa.m_col;
      if (a_ld) begin ld_cnt++; ld_cyc = cyc; end
      if (a_done) begin done_cnt++; done_cyc = cyc; end
      if (ifa.m_valid && fv_cyc < 0) fv_cyc = cyc;
      if (ifa.m_valid && ifa.m_ready) begin
        obs.push_back(ifa.m_data);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
  end

  int rmode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       ifa.m_ready = 1'b1;
      1:       ifa.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: ifa.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic clr_stats();
    ld_cnt = 0; done_cnt = 0; ld_cyc = -1; done_cyc = -1;
    fv_cyc = -1; first_acc = -1; last_acc = -1;
    obs.delete();
  endtask

  // rel is the edge (relative to the start edge) that samples a_gd
  task automatic drive_gd(input int gmode, input int rel);
    for (int c = 0; c < 4; c++) begin
      case (gmode)
        0: a_gd[c] = (rel >= D + 2 && rel <= D + 1 + R) ?
                     32'((rel - D - 2) * 16 + c + 1) : $urandom;
        1: a_gd[c] = $urandom;
        default: a_gd[c] = c[0] ? 32'h8000_0001 : 32'hFFFF_FFFF;
      endcase
    end
  endtask

  task automatic job(input int gmode, input bit pulses,
                     output int sedge);
    int rel;
    clr_stats();
    @(posedge clk);
    #1;
    a_start = 1'b1;
    sedge   = cyc + 1;
    drive_gd(gmode, 0);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      rel = cyc + 1 - sedge;
      a_start = pulses &&
        (rel == 3 || rel == 11 || rel == 20 || rel == 30);
      drive_gd(gmode, rel);
      if (done_cnt > 0 && cyc - done_cyc >= 4) break;
    end
    a_start = 1'b0;
    chk("job_done_once", done_cnt, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, a_busy, 0);
    chk({nm, "_done"}, a_done, 0);
    chk({nm, "_ld"}, a_ld, 0);
    chk({nm, "_valid"}, ifa.m_valid, 0);
    chk({nm, "_last"}, ifa.m_last, 0);
    chk({nm, "_data"}, ifa.m_data, 0);
    chk({nm, "_row"}, ifa.m_row, 0);
    chk({nm, "_col"}, ifa.m_col, 0);
  endtask

  logic [31:0] bw [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    a_start = 1'b0;
    b_start = 1'b0;
    for (int c = 0; c < 4; c++) a_gd[c] = '0;
    bw[0] = 32'hFFFF_0011;
    bw[1] = 32'h8000_0022;
    bw[2] = 32'h0001_0033;
    bw[3] = 32'h7FFF_0044;
    for (int c = 0; c < 4; c++) b_gd[c] = bw[c];
    ifa.m_ready = 1'b1;
    ifb.m_ready = 1'b1;
    clr_stats();

    #12;
    chk_zero("reset");
    chk("reset_b_busy", b_busy, 0);
    chk("reset_b_valid", ifb.m_valid, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // T4: LD_DELAY=0, ROWS=1 build, hand-computed timeline
    #1;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("t4_ld", b_ld, j == 0);
      chk("t4_busy", b_busy, j <= 5);
      chk("t4_done", b_done, j == 6);
      chk("t4_valid", ifb.m_valid, j >= 2 && j <= 5);
      if (j >= 2 && j <= 5) begin
        chk("t4_data", ifb.m_data, bw[j-2]);
        chk("t4_row", ifb.m_row, 0);
        chk("t4_col", ifb.m_col, j - 2);
        chk("t4_last", ifb.m_last, j == 5);
      end
    end

    // T1: basic timing and row-major order
    rmode = 0;
    job(0, 0, s);
    chk("t1_ld_lat", ld_cyc - (s - 1), 9);
    chk("t1_fv_lat", fv_cyc - (s - 1), 14);
    chk("t1_burst", last_acc - first_acc, 15);
    chk("t1_ld_cnt", ld_cnt, 1);
    chk("t1_nwords", obs.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("t1_word", obs[i], 32'((i / 4) * 16 + i % 4 + 1));

    // T2: 1,0,0,1 backpressure
    rmode = 1;
    job(1, 0, s);
    chk("t2_nwords", obs.size(), 16);
    chk("t2_ld_cnt", ld_cnt, 1);

    // T3: start pulses in WAIT, CAPTURE, DRAIN and the done cycle
    rmode = 0;
    job(1, 1, s);
    chk("t3_ld_cnt", ld_cnt, 1);
    chk("t3_nwords", obs.size(), 16);

    // random data under random backpressure
    rmode = 2;
    for (int k = 0; k < 4; k++) begin
      job(1, 0, s);
      chk("rnd_nwords", obs.size(), 16);
    end

    // T5: async reset after the fifth accepted word
    rmode = 0;
    repeat (3) @(posedge clk);
    clr_stats();
    #1;
    a_start = 1'b1;
    drive_gd(1, 0);
    @(posedge clk);
    #1;
    a_start = 1'b0;
    for (int i = 0; i < 100 && obs.size() < 5; i++) begin
      drive_gd(1, 0);
      @(posedge clk);
      #1;
    end
    chk("t5_reached", obs.size(), 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("t5_no_done", done_cnt, 0);
    job(0, 0, s);
    chk("t5_nwords", obs.size(), 16);
    for (int i = 0; i < 4; i++)
      chk("t5_word", obs[i], 32'(i + 1));

    // T6: full-width words pass bit-exact
    job(2, 0, s);
    chk("t6_nwords", obs.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("t6_word", obs[i],
          (i % 2 == 1) ? 32'h8000_0001 : 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
